// File: rtl/gray_thresh_ctrl_pkg.sv
// Shared widths, reset threshold and controller state encoding for the
// adaptive threshold path. The binarizer uses the same DATA_W and DEF_THRESH.
package gray_thresh_ctrl_pkg;

    localparam int DATA_W = 12;
    localparam int CNT_W  = 23;
    localparam int SUM_W  = DATA_W + CNT_W;

    localparam logic [DATA_W-1:0] DEF_THRESH = 12'd1547;

    typedef logic [1:0] ctrlState_t;

    localparam ctrlState_t ST_IDLE = 2'd0;
    localparam ctrlState_t ST_DIV  = 2'd1;
    localparam ctrlState_t ST_HOLD = 2'd2;

endpackage

// File: rtl/gray_thresh_ctrl_if.sv
// Pixel tap, control inputs and threshold outputs of gray_thresh_ctrl.
// The master side drives the stream; the slave side is the controller.
interface gray_thresh_ctrl_if;
    import gray_thresh_ctrl_pkg::*;

    logic                     iFVAL;
    logic                     iDVAL;
    logic        [DATA_W-1:0] iDATA;
    logic                     iMODE;
    logic        [DATA_W-1:0] iMAN_THRESH;
    logic signed [7:0]        iOFFSET;
    logic        [DATA_W-1:0] oTHRESH;
    logic                     oUPDATE;
    logic                     oBUSY;

    modport master (
        output iFVAL, iDVAL, iDATA, iMODE, iMAN_THRESH, iOFFSET,
        input  oTHRESH, oUPDATE, oBUSY
    );

    modport slave (
        input  iFVAL, iDVAL, iDATA, iMODE, iMAN_THRESH, iOFFSET,
        output oTHRESH, oUPDATE, oBUSY
    );

endinterface

// File: rtl/gray_thresh_ctrl_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle over SUM_W cycles.
// oDone marks the final step; the saturated quotient is valid afterwards.
module seq_divider
    import gray_thresh_ctrl_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iStart,
    input  logic [SUM_W-1:0]  iDividend,
    input  logic [CNT_W-1:0]  iDivisor,
    output logic              oBusy,
    output logic              oDone,
    output logic [DATA_W-1:0] oQuot
);

    logic [SUM_W-1:0] quot;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] divisor;
    logic [5:0]       stepCnt;
    logic [CNT_W:0]   remShift;
    logic [CNT_W:0]   remDiff;
    logic             fits;

    function automatic logic [DATA_W-1:0] satQuot(input logic [SUM_W-1:0] q);
        return (|q[SUM_W-1:DATA_W]) ? {DATA_W{1'b1}} : q[DATA_W-1:0];
    endfunction

    always_comb begin
        remShift = {rem, quot[SUM_W-1]};
        remDiff  = remShift - {1'b0, divisor};
        fits     = (remShift >= {1'b0, divisor});
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            quot    <= '0;
            rem     <= '0;
            divisor <= '0;
            stepCnt <= '0;
            oBusy   <= 1'b0;
        end else if (iStart) begin
            quot    <= iDividend;
            rem     <= '0;
            divisor <= iDivisor;
            stepCnt <= 6'(SUM_W);
            oBusy   <= 1'b1;
        end else if (oBusy) begin
            // Remainder stays below the divisor, so CNT_W bits always hold it.
            quot    <= {quot[SUM_W-2:0], fits};
            rem     <= fits ? remDiff[CNT_W-1:0] : remShift[CNT_W-1:0];
            stepCnt <= stepCnt - 6'd1;
            if (stepCnt == 6'd1) oBusy <= 1'b0;
        end
    end

    assign oDone = oBusy && (stepCnt == 6'd1);
    assign oQuot = satQuot(quot);

endmodule

// File: rtl/gray_thresh_ctrl.sv
// Frame-mean threshold controller: accumulates gray pixels per frame, divides
// during blanking and loads mean+offset (or the manual value) while iFVAL is low.
module gray_thresh_ctrl
    import gray_thresh_ctrl_pkg::*;
(
    input logic              iCLK,
    input logic              iRST,
    gray_thresh_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              fvalD;
    logic              rise;
    logic              fall;
    logic [SUM_W-1:0]  accSum;
    logic [CNT_W-1:0]  accCnt;
    ctrlState_t        state;
    logic              divStart;
    logic              divBusy;
    logic              divDone;
    logic [DATA_W-1:0] divQuot;
    logic [DATA_W-1:0] cand;
    logic [DATA_W-1:0] thresh;
    logic              update;

    function automatic logic [DATA_W-1:0] clampThresh(input logic [DATA_W-1:0] mean,
                                                       input logic signed [7:0] off);
        logic signed [DATA_W+1:0] s;
        s = $signed({2'b00, mean}) + $signed({{(DATA_W+2-8){off[7]}}, off});
        if (s[DATA_W+1])   return '0;
        else if (s[DATA_W]) return {DATA_W{1'b1}};
        else               return s[DATA_W-1:0];
    endfunction

    always_comb begin
        rise     = bus.iFVAL && !fvalD;
        fall     = !bus.iFVAL && fvalD;
        divStart = (state == ST_IDLE) && fall && (accCnt != '0);
        cand     = clampThresh(divQuot, bus.iOFFSET);
    end

    // Frame edge detection and pixel accumulation
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            fvalD  <= 1'b0;
            accSum <= '0;
            accCnt <= '0;
        end else begin
            fvalD <= bus.iFVAL;
            if (rise) begin
                accSum <= bus.iDVAL ? SUM_W'(bus.iDATA) : '0;
                accCnt <= bus.iDVAL ? CNT_W'(1) : '0;
            end else if (bus.iFVAL && bus.iDVAL && (accCnt != CNT_MAX)) begin
                accSum <= accSum + SUM_W'(bus.iDATA);
                accCnt <= accCnt + CNT_W'(1);
            end
        end
    end

    seq_divider uDiv (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iStart    (divStart),
        .iDividend (accSum),
        .iDivisor  (accCnt),
        .oBusy     (divBusy),
        .oDone     (divDone),
        .oQuot     (divQuot)
    );

    // Controller FSM; fall edges outside IDLE drop that frame's statistics
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (divStart)     state <= ST_DIV;
                ST_DIV:  if (divDone)      state <= ST_HOLD;
                ST_HOLD: if (!bus.iFVAL)   state <= ST_IDLE;
                default:                   state <= ST_IDLE;
            endcase
        end
    end

    // Threshold register only ever loads while iFVAL is low
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            thresh <= DEF_THRESH;
            update <= 1'b0;
        end else begin
            update <= 1'b0;
            if (bus.iMODE && (state == ST_HOLD) && !bus.iFVAL) begin
                thresh <= cand;
                update <= 1'b1;
            end else if (!bus.iMODE && !bus.iFVAL && (bus.iMAN_THRESH != thresh)) begin
                thresh <= bus.iMAN_THRESH;
                update <= 1'b1;
            end
        end
    end

    assign bus.oTHRESH = thresh;
    assign bus.oUPDATE = update;
    assign bus.oBUSY   = divBusy;

endmodule

// File: tb/tb_gray_thresh_ctrl.sv
// Scoreboard bench for gray_thresh_ctrl: stimulus pushes expected threshold
// loads (value and cycle), a negedge monitor pops them on every oUPDATE.
module tb_gray_thresh_ctrl;
    import gray_thresh_ctrl_pkg::*;

    typedef struct {
        int unsigned th;
        int          cy;
    } expUpd_t;

    logic iCLK;
    logic iRST;
    int   cyc;
    int   errors;
    int   checks;
    int   busyCnt;
    int   t;
    int   t2;
    expUpd_t sb[$];

    gray_thresh_ctrl_if bus();

    gray_thresh_ctrl dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge iCLK);
            cyc = cyc + 1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int unsigned th, input int cy);
        expUpd_t e;
        e.th = th;
        e.cy = cy;
        sb.push_back(e);
    endtask

    // Monitor: every update must match the oldest expected load, value and cycle
    initial begin
        expUpd_t e;
        forever begin
            @(negedge iCLK);
            if (bus.oBUSY) busyCnt = busyCnt + 1;
            if (bus.oUPDATE) begin
                checks = checks + 1;
                if (sb.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_update thresh=%0d cycle=%0d required=none",
                             bus.oTHRESH, cyc);
                end else begin
                    e = sb.pop_front();
                    if ((bus.oTHRESH != e.th[DATA_W-1:0]) || (cyc != e.cy)) begin
                        errors = errors + 1;
                        $display("FAIL update actual thresh=%0d cycle=%0d required thresh=%0d cycle=%0d",
                                 bus.oTHRESH, cyc, e.th, e.cy);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            bus.iFVAL = 1'b0;
            bus.iDVAL = 1'b0;
        end
    endtask

    task automatic pixels(input int n, input logic [11:0] a, b, c, d);
        for (int i = 0; i < n; i++) begin
            tick();
            bus.iFVAL = 1'b1;
            bus.iDVAL = 1'b1;
            case (i % 4)
                0: bus.iDATA = a;
                1: bus.iDATA = b;
                2: bus.iDATA = c;
                default: bus.iDATA = d;
            endcase
        end
    endtask

    task automatic pad(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            bus.iFVAL = 1'b1;
            bus.iDVAL = 1'b0;
        end
    endtask

    task automatic fall(output int tf);
        tick();
        bus.iFVAL = 1'b0;
        bus.iDVAL = 1'b0;
        tf = cyc;
    endtask

    task automatic sendFrame(input int n, input logic [11:0] a, b, c, d,
                             input int nPad, output int tf);
        pixels(n, a, b, c, d);
        pad(nPad);
        fall(tf);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        busyCnt = 0;
        iRST            = 1'b0;
        bus.iFVAL       = 1'b0;
        bus.iDVAL       = 1'b0;
        bus.iDATA       = '0;
        bus.iMODE       = 1'b1;
        bus.iMAN_THRESH = '0;
        bus.iOFFSET     = 8'sd0;

        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        check("reset_thresh", int'(bus.oTHRESH), 1547);
        check("reset_update", int'(bus.oUPDATE), 0);
        check("reset_busy", int'(bus.oBUSY), 0);
        tick();
        iRST = 1'b1;
        idle(5);

        // Auto mode, offset 0: mean of 100..400 is 250
        busyCnt = 0;
        sendFrame(4, 12'd100, 12'd200, 12'd300, 12'd400, 0, t);
        push(250, t + 37);
        idle(45);
        check("busy_cycles", busyCnt, 35);

        bus.iOFFSET = -8'sd128;
        sendFrame(2, 12'd50, 12'd50, 12'd50, 12'd50, 3, t);
        push(0, t + 37);
        idle(45);

        bus.iOFFSET = 8'sd20;
        sendFrame(2, 12'd4090, 12'd4090, 12'd4090, 12'd4090, 0, t);
        push(4095, t + 37);
        idle(45);

        bus.iOFFSET = 8'sd10;
        sendFrame(4, 12'd100, 12'd200, 12'd300, 12'd400, 0, t);
        push(260, t + 37);
        idle(45);

        // Frame without valid pixels leaves the threshold alone
        sendFrame(0, 12'd0, 12'd0, 12'd0, 12'd0, 10, t);
        idle(45);
        check("empty_frame_thresh", int'(bus.oTHRESH), 260);

        // Short blanking: update deferred to the end of the following frame
        bus.iOFFSET = 8'sd0;
        sendFrame(4, 12'd100, 12'd200, 12'd300, 12'd400, 0, t);
        idle(9);
        pixels(4, 12'd1000, 12'd1000, 12'd3000, 12'd3000);
        check("short_blank_start_thresh", int'(bus.oTHRESH), 260);
        pad(36);
        check("short_blank_end_thresh", int'(bus.oTHRESH), 260);
        fall(t2);
        push(250, t2 + 1);
        idle(45);

        // Manual mode with a mid-frame change of the manual value
        bus.iMAN_THRESH = 12'd250;
        bus.iMODE       = 1'b0;
        idle(3);
        pixels(4, 12'd100, 12'd200, 12'd300, 12'd400);
        bus.iMAN_THRESH = 12'd800;
        pad(10);
        check("manual_mid_frame_thresh", int'(bus.oTHRESH), 250);
        fall(t);
        push(800, t + 1);
        idle(45);

        bus.iMODE = 1'b1;
        sendFrame(2, 12'd50, 12'd50, 12'd50, 12'd50, 0, t);
        push(50, t + 37);
        idle(45);

        // Reset while the divider is running
        sendFrame(4, 12'd100, 12'd200, 12'd300, 12'd400, 0, t);
        idle(10);
        iRST = 1'b0;
        #1;
        check("div_reset_thresh", int'(bus.oTHRESH), 1547);
        check("div_reset_busy", int'(bus.oBUSY), 0);
        check("div_reset_update", int'(bus.oUPDATE), 0);
        tick();
        iRST = 1'b1;
        idle(3);
        sendFrame(4, 12'd100, 12'd200, 12'd300, 12'd400, 0, t);
        push(250, t + 37);
        idle(45);

        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        check("pending_updates", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
